// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//
// Shares one 32-bit ripple-carry adder among N_REQ requesters. Grants one
// request at a time in round-robin order and drives the adder from registered
// operands. It then holds those operands for SETTLE_CYCLES cycles so the
// ripple-carry path can settle, captures the sum and presents it on a
// valid/ready result port.
//
// Handshake semantics (both ports): a transfer happens on the rising edge where
// valid && ready are both high. Request side: req_ready is one-hot and only
// ever asserted in IDLE. Result side: res_valid stays high, with all res_*
// stable, until res_ready is seen.
//
// Optional feature macro: ADDER_ARB_OVF_EN adds the res_ovf signed-overflow
// flag, captured together with res_sum.
//
// Ports:
//   Clk, Rst               clock, synchronous active-high reset
//   req_valid/req_ready    per-requester request handshake (ready is one-hot)
//   req_a, req_b, req_cin  flattened operands; requester i owns [32i+31:32i]
//   add_a, add_b, add_cin  registered operands to the shared adder
//   add_sum, add_cout      result returned by the shared adder
//   res_valid/res_ready    result handshake
//   res_sum, res_cout      captured result
//   res_id                 index of the requester owning the result
//   busy                   high whenever the FSM is not IDLE
//   res_ovf                signed overflow (ADDER_ARB_OVF_EN only)
// -----------------------------------------------------------------------------
module adder_arbiter #(
  parameter int N_REQ         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [N_REQ-1:0]     req_cin,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic                 add_cin,
  input  logic [31:0]          add_sum,
  input  logic                 add_cout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_sum,
  output logic                 res_cout,
  output logic [2:0]           res_id,
  output logic                 busy
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                 res_ovf
`endif
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] idx;
  logic             win_found;
  logic [3:0]       cnt;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic             sel_cin;
  int               j;

  // Round-robin search. Scanning offsets from high to low means the last hit
  // written is the lowest offset, i.e. the first valid bit at or after rr_ptr.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    j         = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      idx = PTR_W'(j);
      if (req_valid[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
  end

  assign rr_ptr_nxt = (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);

  // Operand mux for the winning requester.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == PTR_W'(k)) begin
        sel_a   = req_a[32*k +: 32];
        sel_b   = req_b[32*k +: 32];
        sel_cin = req_cin[k];
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found)     state_nxt = SETTLE;
      SETTLE:  if (cnt == 4'd0)   state_nxt = DONE;
      DONE:    if (res_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. Grants are suppressed while Rst is high so no handshake can
  // complete on a resetting edge.
  always_comb begin
    busy      = (state != IDLE);
    req_ready = '0;
    if (state == IDLE && win_found && !Rst) req_ready = N_REQ'(1) << win;
  end

  // Datapath registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rr_ptr    <= '0;
      cnt       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_id    <= '0;
      res_valid <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
      res_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            add_a   <= sel_a;
            add_b   <= sel_b;
            add_cin <= sel_cin;
            res_id  <= 3'(win);
            rr_ptr  <= rr_ptr_nxt;
            cnt     <= 4'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            res_sum   <= add_sum;
            res_cout  <= add_cout;
            res_valid <= 1'b1;
`ifdef ADDER_ARB_OVF_EN
            res_ovf   <= (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);
`endif
          end
        end
        DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//
// Bench for adder_arbiter with N_REQ=4, SETTLE_CYCLES=2. A behavioural adder
// is wired to the add_* ports. The negedge monitor keeps its own round-robin
// pointer, checks every grant against it, and pushes the expected result
// (computed from the granted operands) onto exp_q. It pops and compares on
// each result handshake.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

  localparam int N_REQ = 4;
  localparam int S     = 2;

  // ---------------------------------------------------------------- clock/reset
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUT wiring
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_cin;
  logic [31:0]         add_a, add_b, add_sum;
  logic                add_cin, add_cout;
  logic                res_valid, res_ready, res_cout, busy;
  logic [31:0]         res_sum;
  logic [2:0]          res_id;
`ifdef ADDER_ARB_OVF_EN
  logic                res_ovf;
`endif

  // The shared adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  adder_arbiter #(.N_REQ(N_REQ), .SETTLE_CYCLES(S)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id),
    .busy      (busy)
`ifdef ADDER_ARB_OVF_EN
    ,
    .res_ovf   (res_ovf)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- scoreboard
  // Entry: {ovf, id[2:0], cout, sum[31:0]}
  logic [36:0] exp_q[$];
  int          mdl_ptr = 0;
  int          grant_cyc = 0;
  bit          pending = 0;

  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  always @(negedge Clk) begin
    logic [31:0] ea, eb, es;
    logic        ec, eo;
    logic [32:0] full;
    logic [36:0] ent;
    int          w;
    if (Rst) begin
      exp_q.delete();
      mdl_ptr = 0;
      pending = 0;
    end else begin
      if (req_ready != '0) begin
        w = rr_pick(req_valid, mdl_ptr);
        checks++;
        if (w < 0 || req_ready !== (N_REQ'(1) << w)) begin
          errors++;
          $display("FAIL grant_select: req_ready=%b valid=%b required winner=%0d", req_ready, req_valid, w);
        end
        if (w >= 0) begin
          ea   = req_a[32*w +: 32];
          eb   = req_b[32*w +: 32];
          ec   = req_cin[w];
          full = {1'b0, ea} + {1'b0, eb} + {32'd0, ec};
          es   = full[31:0];
          eo   = (ea[31] == eb[31]) && (es[31] != ea[31]);
          ent  = {eo, 3'(w), full[32], es};
          exp_q.push_back(ent);
          mdl_ptr = (w + 1) % N_REQ;
        end
        grant_cyc = cyc;
        pending   = 1;
      end else if (!busy && (|req_valid)) begin
        checks++;
        errors++;
        $display("FAIL missing_grant: req_ready=%b required a grant for valid=%b", req_ready, req_valid);
      end

      if (res_valid && pending) begin
        checks++;
        if (cyc - grant_cyc != S + 1) begin
          errors++;
          $display("FAIL latency: got %0d cycles required %0d", cyc - grant_cyc, S + 1);
        end
        pending = 0;
      end

      if (res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: sum=%h id=%0d with empty expected queue", res_sum, res_id);
        end else begin
          ent = exp_q.pop_front();
          if ({res_id, res_cout, res_sum} !== ent[35:0]) begin
            errors++;
            $display("FAIL result: got id=%0d cout=%b sum=%h required id=%0d cout=%b sum=%h",
                     res_id, res_cout, res_sum, ent[35:33], ent[32], ent[31:0]);
          end
`ifdef ADDER_ARB_OVF_EN
          checks++;
          if (res_ovf !== ent[36]) begin
            errors++;
            $display("FAIL result_ovf: got %b required %b", res_ovf, ent[36]);
          end
`endif
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i]        = cin;
    req_valid[i]      = 1'b1;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  // Waits (at negedges) for req_ready[i]; returns at that negedge.
  task automatic wait_grant(input int i, output bit ok);
    ok = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge Clk);
      if (req_ready[i]) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Waits (at negedges) for res_valid.
  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge Clk);
      if (res_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge Clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    tick();
  endtask

  // Issues one request and returns at the negedge where res_valid is first high.
  task automatic run_one(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin,
                         output bit ok, output int lat);
    bit g;
    int t;
    set_req(i, a, b, cin);
    wait_grant(i, g);
    t = cyc;
    tick();
    clr_req(i);
    wait_valid(ok);
    ok  = ok && g;
    lat = cyc - t;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    Rst       = 1'b1;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_valid = '1;
    tick();
    tick();
    @(negedge Clk);
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
    checks++;
    if ({res_valid, busy, add_cin, res_cout} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b busy=%b add_cin=%b cout=%b required 0", res_valid, busy, add_cin, res_cout);
    end
    checks++;
    if ({add_a, add_b, res_sum, res_id} !== '0) begin
      errors++;
      $display("FAIL reset_data: got add_a=%h add_b=%h sum=%h id=%0d required 0", add_a, add_b, res_sum, res_id);
    end
`ifdef ADDER_ARB_OVF_EN
    checks++;
    if (res_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b required 0", res_ovf); end
`endif
    tick();
    req_valid = '0;
    Rst       = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    int lat;
    run_one(1, 32'h0000_0005, 32'h0000_0007, 1'b1, ok, lat);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: no grant/result within bound"); end
    checks++;
    if (lat != S + 1) begin errors++; $display("FAIL single_latency: got %0d required %0d", lat, S + 1); end
    checks++;
    if ({res_id, res_cout, res_sum} !== {3'd1, 1'b0, 32'h0000_000D}) begin
      errors++;
      $display("FAIL single_result: got id=%0d cout=%b sum=%h required id=1 cout=0 sum=0000000d", res_id, res_cout, res_sum);
    end
    wait_idle(ok);
  endtask

  task automatic test_carry();
    bit ok;
    int lat;
    run_one(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ok, lat);
    checks++;
    if (!ok || {res_id, res_cout, res_sum} !== {3'd2, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL carry_out: got ok=%b id=%0d cout=%b sum=%h required id=2 cout=1 sum=00000000", ok, res_id, res_cout, res_sum);
    end
`ifdef ADDER_ARB_OVF_EN
    checks++;
    if (res_ovf !== 1'b0) begin errors++; $display("FAIL carry_ovf: got %b required 0", res_ovf); end
`endif
    wait_idle(ok);
    run_one(3, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, ok, lat);
    checks++;
    if (!ok || {res_id, res_cout, res_sum} !== {3'd3, 1'b0, 32'h8000_0000}) begin
      errors++;
      $display("FAIL signed_wrap: got ok=%b id=%0d cout=%b sum=%h required id=3 cout=0 sum=80000000", ok, res_id, res_cout, res_sum);
    end
`ifdef ADDER_ARB_OVF_EN
    checks++;
    if (res_ovf !== 1'b1) begin errors++; $display("FAIL signed_ovf: got %b required 1", res_ovf); end
`endif
    wait_idle(ok);
  endtask

  task automatic test_round_robin();
    bit ok;
    int last = 0;
    int idx;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
    for (int g = 0; g < 5; g++) begin
      ok = 0;
      for (int n = 0; n < 30; n++) begin
        @(negedge Clk);
        if (req_ready != '0) begin
          ok = 1;
          break;
        end
      end
      idx = -1;
      for (int i = 0; i < N_REQ; i++) if (req_ready[i]) idx = i;
      checks++;
      if (!ok || idx != g % N_REQ) begin
        errors++;
        $display("FAIL rr_order: grant %0d got index %0d required %0d", g, idx, g % N_REQ);
      end
      if (g > 0) begin
        checks++;
        if (cyc - last != S + 2) begin
          errors++;
          $display("FAIL rr_spacing: grant %0d got %0d cycles required %0d", g, cyc - last, S + 2);
        end
      end
      last = cyc;
      tick();
      // Operands only need to be valid in the grant cycle.
      for (int i = 0; i < N_REQ; i++) set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    req_valid = '0;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_drain: busy did not drop"); end
  endtask

  task automatic test_backpressure();
    bit ok;
    res_ready = 1'b0;
    set_req(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_grant(0, ok);
    tick();
    clr_req(0);
    set_req(2, 32'h0000_00FF, 32'h0000_0F00, 1'b1);
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: no result within bound"); end
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge Clk);
      checks++;
      if ({res_valid, busy, req_ready, res_id, res_cout, res_sum} !==
          {1'b1, 1'b1, 4'b0000, 3'd0, 1'b0, 32'h2345_6789}) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got valid=%b busy=%b ready=%b id=%0d cout=%b sum=%h required 1 1 0000 0 0 23456789",
                 n, res_valid, busy, req_ready, res_id, res_cout, res_sum);
      end
    end
    tick();
    res_ready = 1'b1;
    @(negedge Clk);
    checks++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_before_edge: res_valid got %b required 1", res_valid); end
    @(negedge Clk);
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_release: res_valid got %b required 0", res_valid); end
    wait_grant(2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_next_grant: requester 2 not granted"); end
    tick();
    clr_req(2);
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_req(2, 32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
    wait_grant(2, ok);
    tick();
    clr_req(2);
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_settle: busy got %b required 1", busy); end
    tick();
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if ({busy, res_valid, add_cin, res_cout, req_ready, add_a, add_b, res_sum, res_id} !== '0) begin
      errors++;
      $display("FAIL mid_reset_zero: busy=%b valid=%b add_a=%h add_b=%h sum=%h id=%0d required all 0",
               busy, res_valid, add_a, add_b, res_sum, res_id);
    end
    tick();
    set_req(1, 32'h0000_1000, 32'h0000_0234, 1'b0);
    set_req(3, 32'h0000_0001, 32'h0000_0002, 1'b0);
    @(negedge Clk);
    checks++;
    if (req_ready !== 4'b0010 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_regrant: got ready=%b valid=%b required ready=0010 valid=0", req_ready, res_valid);
    end
    tick();
    clr_req(1);
    wait_grant(3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_second_grant: requester 3 not granted"); end
    tick();
    clr_req(3);
    wait_idle(ok);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Sequencing arbiter that shares one 32-bit `RippleAdder` among up to `N_REQ` requesters. It grants one request at a time, round-robin, and drives the adder from registered operands. It waits a programmable number of settle cycles to cover the ripple-carry multicycle path, then captures and presents the result on a valid/ready output port. It sits between the client units and the single adder instance, which is wired to the `add_*` ports.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters; legal range 2..8.
- `SETTLE_CYCLES`, 2: cycles the operands are held on the adder before capture; legal range 1..15.

Ports:
- `Clk`  in  1  sole clock; all state updates on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request.
- `req_ready`  out  N_REQ  one-hot grant; the handshake completes when `req_valid[i] && req_ready[i]`.
- `req_a`  in  32*N_REQ  operand A, flattened; requester i uses bits [32i+31:32i].
- `req_b`  in  32*N_REQ  operand B, same packing.
- `req_cin`  in  N_REQ  carry-in per requester.
- `add_a`, `add_b`  out  32  registered operands to the adder.
- `add_cin`  out  1  registered carry-in to the adder.
- `add_sum`  in  32  sum returned by the adder.
- `add_cout`  in  1  carry-out returned by the adder.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_sum`  out  32  captured sum.
- `res_cout`  out  1  captured carry-out.
- `res_id`  out  3  index of the requester that owns the result; upper bits are zero when `N_REQ` < 8.
- `busy`  out  1  high in any state other than IDLE.
- `res_ovf`  out  1  signed overflow flag; present only with `ADDER_ARB_OVF_EN`.

## Operation

The FSM has three states: IDLE, SETTLE, DONE.

- **IDLE**
  - If any `req_valid` is high, the winner is the first set bit at or after `rr_ptr`, searching upward and wrapping modulo `N_REQ`.
  - `req_ready[winner]` is driven combinationally in IDLE only; all other bits are 0.
  - On that edge:
    - the winner's a/b/cin are latched into `add_a`/`add_b`/`add_cin`;
    - the winner index is latched into `res_id`;
    - `rr_ptr` becomes (winner+1) mod `N_REQ`;
    - `cnt` is loaded with `SETTLE_CYCLES-1`;
    - the FSM moves to SETTLE.
  - If no request is valid, the FSM stays in IDLE and `rr_ptr` is unchanged.
- **SETTLE**
  - `add_*` are held stable.
  - If `cnt` != 0, `cnt` decrements.
  - If `cnt` == 0:
    - `add_sum`/`add_cout` are captured into `res_sum`/`res_cout`;
    - `res_valid` is set;
    - the FSM moves to DONE.
- **DONE**
  - `res_*` and `add_*` are held.
  - On `res_valid && res_ready`, `res_valid` clears and the FSM returns to IDLE.
  - Requests are never granted in DONE or SETTLE; `req_ready` is all 0 in those states.
- **Requester rules**
  - A requester may drop `req_valid` before it is granted; no grant results.
  - Operands need to be valid only in the grant cycle.
- **Arithmetic**
  - The result is the plain 32-bit sum from the adder plus its carry-out; the block does not re-compute it.

## Timing

- **Reset value** (`Rst` high at an edge): FSM in IDLE; `rr_ptr`, `cnt`, `add_a`, `add_b`, `add_cin`, `res_sum`, `res_cout`, `res_id`, `res_valid`, `busy` (and `res_ovf`) all 0.
- **During reset:** `req_ready` is forced to 0.
- **Reset mid-operation:** the operation in SETTLE or DONE is aborted and its result is lost; no `res_valid` pulse follows.
- **Latency:** grant handshake at cycle T gives `res_valid` high from cycle T+`SETTLE_CYCLES`+1.
- **Throughput:** with `res_ready` held high, the next grant can occur at T+`SETTLE_CYCLES`+2. DONE lasts at least one cycle, IDLE at least one cycle.
- **Backpressure:** while `res_ready` is low, the block stays in DONE indefinitely with all outputs stable.
- **Pointer wrap:** a grant to index `N_REQ`-1 sets `rr_ptr` to 0.

## Configuration

- **`ADDER_ARB_OVF_EN` defined:**
  - the `res_ovf` port exists;
  - it is captured together with `res_sum` as (`add_a[31]` == `add_b[31]`) && (`add_sum[31]` != `add_a[31]`);
  - it is reset to 0 and held in DONE like the other result outputs.
- **`ADDER_ARB_OVF_EN` undefined:** the port and its register are absent; all other behaviour is identical.

## Test plan

- **Single request:** `SETTLE_CYCLES`=2, requester 1 sends a=0x0000_0005, b=0x0000_0007, cin=1; grant at T.
  - Expect `res_valid` at T+3 with `res_sum`=0x0000_000D, `res_cout`=0, `res_id`=1.
- **Carry-out:** a=0xFFFF_FFFF, b=0x0000_0001, cin=0.
  - Expect `res_sum`=0, `res_cout`=1.
  - With `ADDER_ARB_OVF_EN`: `res_ovf`=0.
  - Separately, a=0x7FFF_FFFF, b=1 gives `res_ovf`=1.
- **Round-robin:** all 4 `req_valid` held high, `res_ready`=1, starting after reset.
  - Expect grant order 0,1,2,3,0.
  - Each next grant follows the previous one by exactly `SETTLE_CYCLES`+2 cycles.
- **Backpressure:** hold `res_ready`=0 for 10 cycles after `res_valid` rises.
  - `res_*` stay stable, `req_ready` stays 0, `busy` stays 1.
  - Raising `res_ready` clears `res_valid` on the next edge.
- **Reset mid-operation:** pulse `Rst` in SETTLE.
  - All outputs read 0 the next cycle and no `res_valid` appears.
  - A request 1 cycle later is granted to the lowest active index (`rr_ptr`=0).
